// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared state encodings and port identifiers for the memory arbiter
package arbitro_pkg;

  typedef enum logic [1:0] {
    LIBRE  = 2'd0,
    ACCESO = 2'd1,
    FIN    = 2'd2
  } estado_t;

  localparam logic PUERTO_CPU = 1'b0;
  localparam logic PUERTO_ES  = 1'b1;

endpackage

// File: rtl/contador_espera.sv
// rtl/contador_espera.sv - 4-bit loadable down-counter with zero flag for memory wait states
module contador_espera (
  input  logic       clk,
  input  logic       reset,
  input  logic       carga,
  input  logic [3:0] valor,
  input  logic       dec,
  output logic       cero
);

  logic [3:0] cuenta;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta <= 4'd0;
    end else if (carga) begin
      cuenta <= valor;
    end else if (dec && (cuenta != 4'd0)) begin
      cuenta <= cuenta - 4'd1;
    end
  end

  assign cero = (cuenta == 4'd0);

endmodule

// File: rtl/arbitro_memoria.sv
// rtl/arbitro_memoria.sv - two-port (CPU / I/O) memory arbiter; ARBITRO_ROUND_ROBIN_EN selects round-robin ties
module arbitro_memoria
  import arbitro_pkg::*;
#(
  parameter int ANCHO_DATO = 16,
  parameter int ANCHO_DIR  = 16,
  parameter int ESPERAS    = 2
) (
  input  logic                  Reloj,
  input  logic                  Reiniciar,
  input  logic                  ReqCPU,
  input  logic                  ReqES,
  input  logic                  WeCPU,
  input  logic                  WeES,
  input  logic [ANCHO_DIR-1:0]  DirCPU,
  input  logic [ANCHO_DIR-1:0]  DirES,
  input  logic [ANCHO_DATO-1:0] DatoCPU,
  input  logic [ANCHO_DATO-1:0] DatoES,
  output logic                  GntCPU,
  output logic                  GntES,
  output logic                  ListoCPU,
  output logic                  ListoES,
  output logic [ANCHO_DATO-1:0] LeidoCPU,
  output logic [ANCHO_DATO-1:0] LeidoES,
  output logic                  MemSel,
  output logic                  MemEsc,
  output logic [ANCHO_DIR-1:0]  MemDir,
  output logic [ANCHO_DATO-1:0] MemDatoEsc,
  input  logic [ANCHO_DATO-1:0] MemDatoLec
);

  localparam logic [3:0] CARGA_ESPERA = 4'(ESPERAS);

  estado_t estado, estado_sig;
  logic    carga, dec, cero;
  logic    hay_req, gana_es;
  logic    ganador, we_l;

  assign hay_req = ReqCPU | ReqES;

`ifdef ARBITRO_ROUND_ROBIN_EN
  logic puntero;

  // On a tie, serve the port that was not granted last.
  assign gana_es = ReqES & (~ReqCPU | (puntero == PUERTO_CPU));

  // Remember the last granted port; reset points at ES so CPU wins the first tie.
  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      puntero <= PUERTO_ES;
    end else if ((estado == LIBRE) && hay_req) begin
      puntero <= gana_es;
    end
  end
`else
  // Fixed priority: CPU takes every tie.
  assign gana_es = ReqES & ~ReqCPU;
`endif

  contador_espera u_contador (
    .clk   (Reloj),
    .reset (Reiniciar),
    .carga (carga),
    .valor (CARGA_ESPERA),
    .dec   (dec),
    .cero  (cero)
  );

  // State register.
  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      estado <= LIBRE;
    end else begin
      estado <= estado_sig;
    end
  end

  // Next-state and counter control.
  always_comb begin
    estado_sig = estado;
    carga      = 1'b0;
    dec        = 1'b0;
    case (estado)
      LIBRE: begin
        if (hay_req) begin
          estado_sig = ACCESO;
          carga      = 1'b1;
        end
      end
      ACCESO: begin
        if (cero) begin
          estado_sig = FIN;
        end else begin
          dec = 1'b1;
        end
      end
      FIN:     estado_sig = LIBRE;
      default: estado_sig = LIBRE;
    endcase
  end

  // Registered outputs: grant/latch on acceptance, drive memory during ACCESO, complete on exit.
  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      ganador    <= PUERTO_CPU;
      we_l       <= 1'b0;
      GntCPU     <= 1'b0;
      GntES      <= 1'b0;
      ListoCPU   <= 1'b0;
      ListoES    <= 1'b0;
      LeidoCPU   <= '0;
      LeidoES    <= '0;
      MemSel     <= 1'b0;
      MemEsc     <= 1'b0;
      MemDir     <= '0;
      MemDatoEsc <= '0;
    end else begin
      ListoCPU <= 1'b0;
      ListoES  <= 1'b0;
      case (estado)
        LIBRE: begin
          if (hay_req) begin
            ganador    <= gana_es;
            we_l       <= gana_es ? WeES : WeCPU;
            GntCPU     <= ~gana_es;
            GntES      <= gana_es;
            MemSel     <= 1'b1;
            MemEsc     <= gana_es ? WeES : WeCPU;
            MemDir     <= gana_es ? DirES : DirCPU;
            MemDatoEsc <= gana_es ? DatoES : DatoCPU;
          end
        end
        ACCESO: begin
          if (cero) begin
            MemSel     <= 1'b0;
            MemEsc     <= 1'b0;
            MemDir     <= '0;
            MemDatoEsc <= '0;
            if (ganador == PUERTO_ES) begin
              ListoES <= 1'b1;
              if (!we_l) LeidoES <= MemDatoLec;
            end else begin
              ListoCPU <= 1'b1;
              if (!we_l) LeidoCPU <= MemDatoLec;
            end
          end
        end
        FIN: begin
          GntCPU <= 1'b0;
          GntES  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// tb/tb_arbitro_memoria.sv - randomized self-checking bench for arbitro_memoria (ESPERAS=2 and ESPERAS=0 instances)
module tb_arbitro_memoria;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_cpu, req_es, we_cpu, we_es;
  logic [15:0] dir_cpu, dir_es, dato_cpu, dato_es, lec;

  logic [1:0]  gnt_cpu, gnt_es, listo_cpu, listo_es, mem_sel, mem_esc;
  logic [15:0] leido_cpu [2];
  logic [15:0] leido_es [2];
  logic [15:0] mem_dir [2];
  logic [15:0] mem_dato_esc [2];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Transaction-level reference: each accepted access occupies a fixed window of cycles.
  int          free_at [2];
  int          st [2];
  bit          act [2];
  bit          win [2];
  bit          wel [2];
  bit          rr_last [2];
  logic [15:0] dirl [2];
  logic [15:0] datol [2];
  logic [15:0] leido_m [2][2];

  always #5 clk = ~clk;

  arbitro_memoria #(.ANCHO_DATO(16), .ANCHO_DIR(16), .ESPERAS(2)) u0 (
    .Reloj(clk), .Reiniciar(rst),
    .ReqCPU(req_cpu), .ReqES(req_es), .WeCPU(we_cpu), .WeES(we_es),
    .DirCPU(dir_cpu), .DirES(dir_es), .DatoCPU(dato_cpu), .DatoES(dato_es),
    .GntCPU(gnt_cpu[0]), .GntES(gnt_es[0]), .ListoCPU(listo_cpu[0]), .ListoES(listo_es[0]),
    .LeidoCPU(leido_cpu[0]), .LeidoES(leido_es[0]),
    .MemSel(mem_sel[0]), .MemEsc(mem_esc[0]), .MemDir(mem_dir[0]), .MemDatoEsc(mem_dato_esc[0]),
    .MemDatoLec(lec)
  );

  arbitro_memoria #(.ANCHO_DATO(16), .ANCHO_DIR(16), .ESPERAS(0)) u1 (
    .Reloj(clk), .Reiniciar(rst),
    .ReqCPU(req_cpu), .ReqES(req_es), .WeCPU(we_cpu), .WeES(we_es),
    .DirCPU(dir_cpu), .DirES(dir_es), .DatoCPU(dato_cpu), .DatoES(dato_es),
    .GntCPU(gnt_cpu[1]), .GntES(gnt_es[1]), .ListoCPU(listo_cpu[1]), .ListoES(listo_es[1]),
    .LeidoCPU(leido_cpu[1]), .LeidoES(leido_es[1]),
    .MemSel(mem_sel[1]), .MemEsc(mem_esc[1]), .MemDir(mem_dir[1]), .MemDatoEsc(mem_dato_esc[1]),
    .MemDatoLec(lec)
  );

  function automatic int esp_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    else n_pass++;
  endtask

  // Apply one clock edge to the reference using the inputs currently driven.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int e;
      bit w;
      e = esp_of(i);
      if (rst) begin
        act[i] = 1'b0;
        free_at[i] = cyc + 1;
        leido_m[i][0] = '0;
        leido_m[i][1] = '0;
        rr_last[i] = 1'b1;
      end else begin
        if (act[i] && (cyc == st[i] + e + 1) && !wel[i]) leido_m[i][win[i]] = lec;
        if ((cyc >= free_at[i]) && (req_cpu || req_es)) begin
          if (req_cpu && req_es) begin
`ifdef ARBITRO_ROUND_ROBIN_EN
            w = !rr_last[i];
`else
            w = 1'b0;
`endif
          end else begin
            w = req_es;
          end
          rr_last[i] = w;
          act[i]     = 1'b1;
          st[i]      = cyc;
          win[i]     = w;
          wel[i]     = w ? we_es : we_cpu;
          dirl[i]    = w ? dir_es : dir_cpu;
          datol[i]   = w ? dato_es : dato_cpu;
          free_at[i] = cyc + e + 3;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int  e;
      bit  in_acc, en_fin, gnt;
      e      = esp_of(i);
      in_acc = act[i] && (cyc >= st[i] + 1) && (cyc <= st[i] + e + 1);
      en_fin = act[i] && (cyc == st[i] + e + 2);
      gnt    = in_acc || en_fin;
      check($sformatf("u%0d.gnt_cpu", i), gnt_cpu[i], gnt && !win[i]);
      check($sformatf("u%0d.gnt_es", i), gnt_es[i], gnt && win[i]);
      check($sformatf("u%0d.listo_cpu", i), listo_cpu[i], en_fin && !win[i]);
      check($sformatf("u%0d.listo_es", i), listo_es[i], en_fin && win[i]);
      check($sformatf("u%0d.mem_sel", i), mem_sel[i], in_acc);
      check($sformatf("u%0d.mem_esc", i), mem_esc[i], in_acc && wel[i]);
      check($sformatf("u%0d.mem_dir", i), mem_dir[i], in_acc ? dirl[i] : 16'h0);
      check($sformatf("u%0d.mem_dato_esc", i), mem_dato_esc[i], in_acc ? datol[i] : 16'h0);
      check($sformatf("u%0d.leido_cpu", i), leido_cpu[i], leido_m[i][0]);
      check($sformatf("u%0d.leido_es", i), leido_es[i], leido_m[i][1]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    req_cpu = 1'b0;
    req_es  = 1'b0;
  endtask

  task automatic randomize_inputs();
    we_cpu   = 1'($urandom);
    we_es    = 1'($urandom);
    dir_cpu  = 16'($urandom);
    dir_es   = 16'($urandom);
    dato_cpu = 16'($urandom);
    dato_es  = 16'($urandom);
    lec      = 16'($urandom);
  endtask

  initial begin
    int n_esc, n_lcpu, n_les;
    for (int i = 0; i < 2; i++) begin
      free_at[i] = 0; st[i] = 0; act[i] = 1'b0; win[i] = 1'b0; wel[i] = 1'b0;
      rr_last[i] = 1'b1; dirl[i] = '0; datol[i] = '0;
      leido_m[i][0] = '0; leido_m[i][1] = '0;
    end

    // Reset with random inputs
    rst = 1'b1;
    req_cpu = 1'($urandom); req_es = 1'($urandom);
    randomize_inputs();
    @(negedge clk);
    step();
    req_cpu = 1'($urandom); req_es = 1'($urandom);
    randomize_inputs();
    step();
    rst = 1'b0;
    idle();
    step();

    // CPU read; request dropped in cycle 1
    req_cpu = 1'b1; we_cpu = 1'b0; dir_cpu = 16'h0040; lec = 16'hA5A5;
    step();
    idle();
    repeat (4) step();
    check("cpu_read_leido", leido_cpu[0], 16'hA5A5);
    check("cpu_read_leido_e0", leido_cpu[1], 16'hA5A5);
    step();

    // ES write
    req_es = 1'b1; we_es = 1'b1; dir_es = 16'h0010; dato_es = 16'h1234; lec = 16'hFFFF;
    n_esc = 0;
    step();
    idle();
    repeat (6) begin
      if (mem_esc[0] && mem_dir[0] == 16'h0010 && mem_dato_esc[0] == 16'h1234) n_esc++;
      step();
    end
    check("es_write_cycles", n_esc, 3);
    check("es_write_leido_es", leido_es[0], 16'h0000);

    // Both requests held for four accesses
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_cpu = 1'b1; req_es = 1'b1; we_cpu = 1'b0; we_es = 1'b0;
    n_lcpu = 0; n_les = 0;
    repeat (19) begin
      step();
      n_lcpu += int'(listo_cpu[0]);
      n_les  += int'(listo_es[0]);
    end
    idle();
    repeat (3) step();
`ifdef ARBITRO_ROUND_ROBIN_EN
    check("tie_cpu_count", n_lcpu, 2);
    check("tie_es_count", n_les, 2);
`else
    check("tie_cpu_count", n_lcpu, 4);
    check("tie_es_count", n_les, 0);
`endif

    // Reset during the second ACCESO cycle, then a fresh CPU request
    req_cpu = 1'b1; we_cpu = 1'b0; dir_cpu = 16'h0077; lec = 16'h5A5A;
    step();
    idle();
    step();
    rst = 1'b1;
    step();
    check("rst_mid_listo", listo_cpu[0], 1'b0);
    check("rst_mid_leido", leido_cpu[0], 16'h0000);
    rst = 1'b0;
    step();
    req_cpu = 1'b1;
    n_lcpu = 0;
    step();
    idle();
    repeat (5) begin
      step();
      n_lcpu += int'(listo_cpu[0]);
    end
    check("reissue_listo_count", n_lcpu, 1);
    check("reissue_leido", leido_cpu[0], 16'h5A5A);

    // Randomized traffic
    repeat (600) begin
      rst     = ($urandom_range(0, 59) == 0);
      req_cpu = ($urandom_range(0, 2) == 0);
      req_es  = ($urandom_range(0, 2) == 0);
      randomize_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
